// File: rtl/wb_commit_arbiter_if.sv
// Writeback bus between the EXU/LSU producers, the register file
// and the commit monitor.
interface wb_commit_arbiter_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
);
   logic             exu_valid_i;
   logic             exu_ready_o;
   logic             exu_rd_we_i;
   logic [4:0]       exu_rd_i;
   logic [XLEN-1:0]  exu_data_i;
   logic [XLEN-1:0]  exu_pc_i;

   logic             lsu_valid_i;
   logic             lsu_ready_o;
   logic             lsu_rd_we_i;
   logic [4:0]       lsu_rd_i;
   logic [XLEN-1:0]  lsu_data_i;
   logic [XLEN-1:0]  lsu_pc_i;

   logic             rf_we_o;
   logic [4:0]       rf_waddr_o;
   logic [XLEN-1:0]  rf_wdata_o;

   logic             commit_valid_o;
   logic [XLEN-1:0]  commit_pc_o;
   logic [CNT_W-1:0] commit_cnt_o;

   modport master (
      output exu_valid_i, exu_rd_we_i, exu_rd_i,
             exu_data_i, exu_pc_i,
      input  exu_ready_o,
      output lsu_valid_i, lsu_rd_we_i, lsu_rd_i,
             lsu_data_i, lsu_pc_i,
      input  lsu_ready_o,
      input  rf_we_o, rf_waddr_o, rf_wdata_o,
      input  commit_valid_o, commit_pc_o, commit_cnt_o
   );

   modport slave (
      input  exu_valid_i, exu_rd_we_i, exu_rd_i,
             exu_data_i, exu_pc_i,
      output exu_ready_o,
      input  lsu_valid_i, lsu_rd_we_i, lsu_rd_i,
             lsu_data_i, lsu_pc_i,
      output lsu_ready_o,
      output rf_we_o, rf_waddr_o, rf_wdata_o,
      output commit_valid_o, commit_pc_o, commit_cnt_o
   );
endinterface

// File: rtl/wb_commit_arbiter.sv
// Round-robin EXU/LSU arbiter for the single register-file write
// port, followed by a one-cycle commit pulse and retire counter.
module wb_commit_arbiter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   wb_commit_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      COMMIT = 2'b01
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic             last_grant;
   logic             grant;
   logic             idle;
   logic             exu_ready;
   logic             lsu_ready;
   logic             xfer;
   logic             sel_we;
   logic [4:0]       sel_rd;
   logic [XLEN-1:0]  sel_data;
   logic [XLEN-1:0]  sel_pc;
   logic             rf_we;
   logic [XLEN-1:0]  pc_q;
   logic [CNT_W-1:0] cnt_q;

   // Contested rounds go to the source that lost the previous one.
   always_comb begin
      grant = ~last_grant;
      unique case (1'b1)
         (bus.exu_valid_i & ~bus.lsu_valid_i): grant = 1'b0;
         (bus.lsu_valid_i & ~bus.exu_valid_i): grant = 1'b1;
         default:                              grant = ~last_grant;
      endcase
   end

   always_comb begin
      idle      = (state == IDLE);
      exu_ready = idle & ~grant & ~reset;
      lsu_ready = idle &  grant & ~reset;
      xfer      = (bus.exu_valid_i & exu_ready)
                | (bus.lsu_valid_i & lsu_ready);
   end

   always_comb begin
      sel_we   = bus.exu_rd_we_i;
      sel_rd   = bus.exu_rd_i;
      sel_data = bus.exu_data_i;
      sel_pc   = bus.exu_pc_i;
      if (grant) begin
         sel_we   = bus.lsu_rd_we_i;
         sel_rd   = bus.lsu_rd_i;
         sel_data = bus.lsu_data_i;
         sel_pc   = bus.lsu_pc_i;
      end
   end

   // x0 writes are dropped here; the instruction still commits.
   assign rf_we = xfer & sel_we & (sel_rd != 5'd0);

   always_comb begin
      state_nx = IDLE;
      unique case (state)
         IDLE:    state_nx = xfer ? COMMIT : IDLE;
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         pc_q       <= '0;
         cnt_q      <= '0;
      end else begin
         state <= state_nx;
         if (xfer) begin
            last_grant <= grant;
            pc_q       <= sel_pc;
         end
         if (state == COMMIT)
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.exu_ready_o    = exu_ready;
   assign bus.lsu_ready_o    = lsu_ready;
   assign bus.rf_we_o        = rf_we;
   assign bus.rf_waddr_o     = rf_we ? sel_rd : 5'd0;
   assign bus.rf_wdata_o     = rf_we ? sel_data : '0;
   assign bus.commit_valid_o = (state == COMMIT);
   assign bus.commit_pc_o    = pc_q;
   assign bus.commit_cnt_o   = cnt_q;

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Directed stimulus with a commit scoreboard for wb_commit_arbiter.
// Accepted PCs are queued and matched against the commit pulses.
module tb_wb_commit_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   wb_commit_arbiter_if #(.XLEN(32), .CNT_W(64)) bus ();

   wb_commit_arbiter #(.XLEN(32), .CNT_W(64)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] pc;
      int          c;
   } exp_t;

   exp_t        q[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc   = 0;
   bit          mon_on = 1'b0;
   logic [63:0] m_cnt = '0;
   int          ei;
   int          li;
   bit          w;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic next();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_src();
      bus.exu_valid_i = 1'b0;
      bus.exu_rd_we_i = 1'b0;
      bus.exu_rd_i    = '0;
      bus.exu_data_i  = '0;
      bus.exu_pc_i    = '0;
      bus.lsu_valid_i = 1'b0;
      bus.lsu_rd_we_i = 1'b0;
      bus.lsu_rd_i    = '0;
      bus.lsu_data_i  = '0;
      bus.lsu_pc_i    = '0;
   endtask

   task automatic set_exu(input logic we, input logic [4:0] rd,
                          input logic [31:0] d,
                          input logic [31:0] pc);
      bus.exu_valid_i = 1'b1;
      bus.exu_rd_we_i = we;
      bus.exu_rd_i    = rd;
      bus.exu_data_i  = d;
      bus.exu_pc_i    = pc;
   endtask

   task automatic set_lsu(input logic we, input logic [4:0] rd,
                          input logic [31:0] d,
                          input logic [31:0] pc);
      bus.lsu_valid_i = 1'b1;
      bus.lsu_rd_we_i = we;
      bus.lsu_rd_i    = rd;
      bus.lsu_data_i  = d;
      bus.lsu_pc_i    = pc;
   endtask

   task automatic push(input logic [31:0] pc);
      exp_t e;
      e.pc = pc;
      e.c  = cyc;
      q.push_back(e);
   endtask

   // Leaves reset high; the caller releases it in its next cycle.
   task automatic do_reset();
      next();
      reset = 1'b1;
      idle_src();
      next();
   endtask

   // Scoreboard: each accept must retire exactly one cycle later.
   always @(negedge clock) begin
      bit e;
      if (mon_on) begin
         if (reset) begin
            q.delete();
            m_cnt = '0;
         end else begin
            e = (q.size() > 0) && (q[0].c < cyc);
            chk("commit_cnt", bus.commit_cnt_o, m_cnt);
            chk("commit_valid", 64'(bus.commit_valid_o), 64'(e));
            if (e) begin
               chk("commit_pc", 64'(bus.commit_pc_o), 64'(q[0].pc));
               void'(q.pop_front());
               m_cnt = m_cnt + 64'd1;
            end
         end
      end
   end

   assert property (@(posedge clock) disable iff (reset)
      (bus.exu_valid_i && !bus.exu_ready_o) |=> bus.exu_valid_i)
      else $error("FAIL exu_valid_dropped");

   assert property (@(posedge clock) disable iff (reset)
      (bus.lsu_valid_i && !bus.lsu_ready_o) |=> bus.lsu_valid_i)
      else $error("FAIL lsu_valid_dropped");

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      idle_src();

      // Reset values, with EXU already requesting.
      do_reset();
      mon_on = 1'b1;
      set_exu(1'b1, 5'd5, 32'hDEADBEEF, 32'h80000000);
      #1;
      chk("rst_exu_rdy", 64'(bus.exu_ready_o), 0);
      chk("rst_lsu_rdy", 64'(bus.lsu_ready_o), 0);
      chk("rst_rf_we", 64'(bus.rf_we_o), 0);
      chk("rst_waddr", 64'(bus.rf_waddr_o), 0);
      chk("rst_wdata", 64'(bus.rf_wdata_o), 0);
      chk("rst_cvalid", 64'(bus.commit_valid_o), 0);
      chk("rst_cpc", 64'(bus.commit_pc_o), 0);
      chk("rst_cnt", bus.commit_cnt_o, 0);

      // Single EXU write.
      next();
      reset = 1'b0;
      #1;
      chk("s_exu_rdy", 64'(bus.exu_ready_o), 1);
      chk("s_lsu_rdy", 64'(bus.lsu_ready_o), 0);
      chk("s_rf_we", 64'(bus.rf_we_o), 1);
      chk("s_waddr", 64'(bus.rf_waddr_o), 5);
      chk("s_wdata", 64'(bus.rf_wdata_o), 64'hDEADBEEF);
      push(32'h80000000);
      next();
      bus.exu_valid_i = 1'b0;
      #1;
      chk("s_cvalid", 64'(bus.commit_valid_o), 1);
      chk("s_cpc", 64'(bus.commit_pc_o), 64'h80000000);
      chk("s_busy_rdy", 64'(bus.exu_ready_o), 0);
      next();
      #1;
      chk("s_cnt", bus.commit_cnt_o, 1);
      chk("s_cvalid_off", 64'(bus.commit_valid_o), 0);

      // Contention: both held, EXU wins first after reset.
      do_reset();
      ei = 0;
      li = 0;
      next();
      reset = 1'b0;
      set_exu(1'b1, 5'(1 + ei), 32'h1000 + ei,
              32'h80001000 + 4 * ei);
      set_lsu(1'b1, 5'(16 + li), 32'h2000 + li,
              32'h80002000 + 4 * li);
      for (int k = 0; k < 4; k++) begin
         w = k[0];
         #1;
         chk("c_exu_rdy", 64'(bus.exu_ready_o), 64'(!w));
         chk("c_lsu_rdy", 64'(bus.lsu_ready_o), 64'(w));
         chk("c_rf_we", 64'(bus.rf_we_o), 1);
         chk("c_waddr", 64'(bus.rf_waddr_o),
             w ? 64'(16 + li) : 64'(1 + ei));
         chk("c_wdata", 64'(bus.rf_wdata_o),
             w ? 64'(32'h2000 + li) : 64'(32'h1000 + ei));
         push(w ? 32'h80002000 + 4 * li
                : 32'h80001000 + 4 * ei);
         next();
         if (!w) begin
            ei++;
            set_exu(1'b1, 5'(1 + ei), 32'h1000 + ei,
                    32'h80001000 + 4 * ei);
         end else begin
            li++;
            if (k == 3)
               bus.lsu_valid_i = 1'b0;
            else
               set_lsu(1'b1, 5'(16 + li), 32'h2000 + li,
                       32'h80002000 + 4 * li);
         end
         #1;
         chk("c_busy_exu", 64'(bus.exu_ready_o), 0);
         chk("c_busy_lsu", 64'(bus.lsu_ready_o), 0);
         next();
      end
      #1;
      chk("c_cnt4", bus.commit_cnt_o, 4);
      chk("c_tail_rdy", 64'(bus.exu_ready_o), 1);
      chk("c_tail_waddr", 64'(bus.rf_waddr_o), 3);
      push(32'h80001000 + 4 * ei);
      next();
      bus.exu_valid_i = 1'b0;
      next();

      // x0 destination: no write, still commits.
      do_reset();
      next();
      reset = 1'b0;
      set_lsu(1'b1, 5'd0, 32'h55, 32'h80000010);
      #1;
      chk("z_lsu_rdy", 64'(bus.lsu_ready_o), 1);
      chk("z_rf_we", 64'(bus.rf_we_o), 0);
      chk("z_waddr", 64'(bus.rf_waddr_o), 0);
      chk("z_wdata", 64'(bus.rf_wdata_o), 0);
      push(32'h80000010);
      next();
      bus.lsu_valid_i = 1'b0;
      #1;
      chk("z_cpc", 64'(bus.commit_pc_o), 64'h80000010);
      next();
      #1;
      chk("z_cnt", bus.commit_cnt_o, 1);

      // LSU request arriving during COMMIT waits one cycle.
      do_reset();
      next();
      reset = 1'b0;
      set_exu(1'b1, 5'd3, 32'h33, 32'h80000020);
      #1;
      chk("b_exu_rdy", 64'(bus.exu_ready_o), 1);
      push(32'h80000020);
      next();
      bus.exu_valid_i = 1'b0;
      set_lsu(1'b1, 5'd4, 32'h44, 32'h80000024);
      #1;
      chk("b_lsu_wait", 64'(bus.lsu_ready_o), 0);
      chk("b_rf_we_busy", 64'(bus.rf_we_o), 0);
      next();
      #1;
      chk("b_lsu_rdy", 64'(bus.lsu_ready_o), 1);
      chk("b_rf_we", 64'(bus.rf_we_o), 1);
      chk("b_waddr", 64'(bus.rf_waddr_o), 4);
      chk("b_wdata", 64'(bus.rf_wdata_o), 64'h44);
      push(32'h80000024);
      next();
      bus.lsu_valid_i = 1'b0;
      #1;
      chk("b_cvalid", 64'(bus.commit_valid_o), 1);
      chk("b_cpc", 64'(bus.commit_pc_o), 64'h80000024);

      // Reset during COMMIT discards the retire.
      do_reset();
      next();
      reset = 1'b0;
      set_exu(1'b1, 5'd6, 32'h66, 32'h80000030);
      #1;
      chk("r_exu_rdy", 64'(bus.exu_ready_o), 1);
      push(32'h80000030);
      next();
      bus.exu_valid_i = 1'b0;
      reset = 1'b1;
      next();
      reset = 1'b0;
      set_lsu(1'b1, 5'd8, 32'h88, 32'h80000034);
      #1;
      chk("r_cvalid", 64'(bus.commit_valid_o), 0);
      chk("r_cnt", bus.commit_cnt_o, 0);
      chk("r_idle_rdy", 64'(bus.lsu_ready_o), 1);
      push(32'h80000034);
      next();
      bus.lsu_valid_i = 1'b0;
      next();

      // Instruction without a destination register.
      do_reset();
      next();
      reset = 1'b0;
      set_exu(1'b0, 5'd7, 32'h77, 32'h80000004);
      #1;
      chk("n_exu_rdy", 64'(bus.exu_ready_o), 1);
      chk("n_rf_we", 64'(bus.rf_we_o), 0);
      chk("n_waddr", 64'(bus.rf_waddr_o), 0);
      push(32'h80000004);
      next();
      bus.exu_valid_i = 1'b0;
      #1;
      chk("n_cvalid", 64'(bus.commit_valid_o), 1);
      chk("n_cpc", 64'(bus.commit_pc_o), 64'h80000004);
      next();
      next();
      next();
      chk("q_empty", 64'(q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
